// File: rtl/irq_controller.sv
// External-interrupt front end: per-source synchronisers, edge/level capture,
// masking, fixed-priority arbitration and an ack/eoi service handshake.
module irq_controller #(
    parameter  int NUM_IRQ     = 8,
    parameter  int SYNC_STAGES = 2,
    localparam int ID_W        = $clog2(NUM_IRQ)
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [NUM_IRQ-1:0] edge_mode,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic               irq_ack,
    input  logic               irq_eoi,
    input  logic               ovf_clr,
    output logic               ExtIRQ,
    output logic [ID_W-1:0]    irq_id,
    output logic               irq_busy,
    output logic [NUM_IRQ-1:0] pending,
    output logic [NUM_IRQ-1:0] overflow
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ASSERT,
        S_SERVICE
    } stateT;

    stateT              state;
    logic [NUM_IRQ-1:0] syncReg [SYNC_STAGES];
    logic [NUM_IRQ-1:0] syncLast;
    logic [NUM_IRQ-1:0] prevSync;
    logic [NUM_IRQ-1:0] edgeDet;
    logic [NUM_IRQ-1:0] ackClr;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] pendingNext;
    logic [NUM_IRQ-1:0] overflowNext;
    logic [ID_W-1:0]    winner;
    logic               ackTaken;

    assign syncLast = syncReg[SYNC_STAGES-1];
    assign edgeDet  = syncLast & ~prevSync;
    assign eligible = pending & ~irq_mask;
    assign ackTaken = (state == S_ASSERT) && irq_ack;
    assign ackClr   = ackTaken ? (NUM_IRQ'(1) << irq_id) : '0;

    // Edge sources: a new edge outranks the ack clear. Level sources mirror the input.
    assign pendingNext  = (edge_mode & (edgeDet | (pending & ~ackClr)))
                        | (~edge_mode & syncLast);
    assign overflowNext = (edge_mode & edgeDet & pending & ~ackClr)
                        | (overflow & {NUM_IRQ{~ovf_clr}});

    // Lowest index wins; scanning downward lets the last hit be the lowest.
    always_comb begin
        // NOTE: default assignment first so no path leaves winner unassigned (no latch).
        winner = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) winner = ID_W'(i);
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            // NOTE: the synchroniser array is flops, not RAM, so every stage is reset.
            for (int k = 0; k < SYNC_STAGES; k++) syncReg[k] <= '0;
            prevSync <= '0;
            pending  <= '0;
            overflow <= '0;
        end else begin
            // NOTE: non-blocking assignments so each stage samples the previous stage's old value.
            syncReg[0] <= irq_in;
            for (int k = 1; k < SYNC_STAGES; k++) syncReg[k] <= syncReg[k-1];
            prevSync <= syncLast;
            pending  <= pendingNext;
            overflow <= overflowNext;
        end
    end

    // Outputs are registered alongside the state so they follow the next state without glitches.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            ExtIRQ   <= 1'b0;
            irq_busy <= 1'b0;
            irq_id   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (eligible != '0) begin
                        state  <= S_ASSERT;
                        ExtIRQ <= 1'b1;
                        irq_id <= winner;
                    end
                end
                S_ASSERT: begin
                    if (irq_ack) begin
                        state    <= S_SERVICE;
                        ExtIRQ   <= 1'b0;
                        irq_busy <= 1'b1;
                    end else if (!eligible[irq_id]) begin
                        state  <= S_IDLE;
                        ExtIRQ <= 1'b0;
                    end
                end
                S_SERVICE: begin
                    if (irq_eoi) begin
                        state    <= S_IDLE;
                        irq_busy <= 1'b0;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    ExtIRQ   <= 1'b0;
                    irq_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// Scenario bench for irq_controller: expected source IDs are queued when stimulus is
// applied and popped when ExtIRQ is raised; state/flag checks are done inline.
module tb_irq_controller;

    localparam int NUM_IRQ = 8;
    localparam int ID_W    = $clog2(NUM_IRQ);

    logic               CLOCK_50 = 1'b0;
    logic               reset    = 1'b0;
    logic [NUM_IRQ-1:0] irq_in   = '0;
    logic [NUM_IRQ-1:0] edge_mode = 8'b1111_1011;
    logic [NUM_IRQ-1:0] irq_mask = '0;
    logic               irq_ack  = 1'b0;
    logic               irq_eoi  = 1'b0;
    logic               ovf_clr  = 1'b0;
    logic               ExtIRQ;
    logic [ID_W-1:0]    irq_id;
    logic               irq_busy;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] overflow;

    int checks = 0;
    int errors = 0;
    logic [ID_W-1:0] expQ [$];

    irq_controller #(.NUM_IRQ(NUM_IRQ), .SYNC_STAGES(2)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .irq_in   (irq_in),
        .edge_mode(edge_mode),
        .irq_mask (irq_mask),
        .irq_ack  (irq_ack),
        .irq_eoi  (irq_eoi),
        .ovf_clr  (ovf_clr),
        .ExtIRQ   (ExtIRQ),
        .irq_id   (irq_id),
        .irq_busy (irq_busy),
        .pending  (pending),
        .overflow (overflow)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    task automatic pulseAck();
        irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0;
    endtask

    task automatic pulseEoi();
        irq_eoi = 1'b1;
        tick(1);
        irq_eoi = 1'b0;
    endtask

    // Wait (bounded) for ExtIRQ, then pop the scoreboard and compare the ID.
    task automatic waitExt(input string name, input int maxCyc);
        int n = 0;
        logic [ID_W-1:0] exp;
        while (ExtIRQ !== 1'b1 && n < maxCyc) begin
            tick(1);
            n++;
        end
        checks++;
        if (ExtIRQ !== 1'b1) begin
            errors++;
            $display("FAIL %s timeout: ExtIRQ=%b after %0d cycles, required 1", name, ExtIRQ, n);
        end else if (expQ.size() == 0) begin
            errors++;
            $display("FAIL %s unexpected request: irq_id=%0d, required none", name, irq_id);
        end else begin
            exp = expQ.pop_front();
            if (irq_id !== exp) begin
                errors++;
                $display("FAIL %s irq_id: got %0d required %0d", name, irq_id, exp);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(3);
        checks++;
        if ({ExtIRQ, irq_busy, irq_id, pending, overflow} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ExtIRQ=%b busy=%b id=%0d pend=%h ovf=%h required all 0",
                     ExtIRQ, irq_busy, irq_id, pending, overflow);
        end
        reset = 1'b1;
    endtask

    task automatic test_edge_latency();
        logic [ID_W-1:0] exp;
        irq_in[3] = 1'b1;
        expQ.push_back(ID_W'(3));
        tick(2);
        irq_in[3] = 1'b0;
        checks++;
        if (pending[3] !== 1'b0) begin
            errors++;
            $display("FAIL lat_pend_early: got %b required 0", pending[3]);
        end
        tick(1);
        checks++;
        if (pending[3] !== 1'b1 || ExtIRQ !== 1'b0) begin
            errors++;
            $display("FAIL lat_pend: pend3=%b ExtIRQ=%b required 1 0", pending[3], ExtIRQ);
        end
        tick(1);
        exp = expQ.pop_front();
        checks++;
        if (ExtIRQ !== 1'b1 || irq_id !== exp) begin
            errors++;
            $display("FAIL lat_ext: ExtIRQ=%b id=%0d required 1 %0d", ExtIRQ, irq_id, exp);
        end
        pulseAck();
        checks++;
        if (ExtIRQ !== 1'b0 || irq_busy !== 1'b1 || pending[3] !== 1'b0) begin
            errors++;
            $display("FAIL ack_service: ExtIRQ=%b busy=%b pend3=%b required 0 1 0",
                     ExtIRQ, irq_busy, pending[3]);
        end
        pulseEoi();
        tick(1);
        checks++;
        if (irq_busy !== 1'b0 || ExtIRQ !== 1'b0) begin
            errors++;
            $display("FAIL eoi_idle: busy=%b ExtIRQ=%b required 0 0", irq_busy, ExtIRQ);
        end
    endtask

    task automatic test_priority();
        irq_in[5] = 1'b1;
        irq_in[1] = 1'b1;
        expQ.push_back(ID_W'(1));
        expQ.push_back(ID_W'(5));
        tick(2);
        irq_in[5] = 1'b0;
        irq_in[1] = 1'b0;
        waitExt("prio_first", 8);
        checks++;
        if (pending[5] !== 1'b1) begin
            errors++;
            $display("FAIL prio_pend5: got %b required 1", pending[5]);
        end
        pulseAck();
        pulseEoi();
        waitExt("prio_second", 4);
        pulseAck();
        pulseEoi();
    endtask

    task automatic test_level_mask();
        irq_in[2] = 1'b1;
        expQ.push_back(ID_W'(2));
        waitExt("lvl_first", 8);
        irq_mask[2] = 1'b1;
        tick(1);
        checks++;
        if (ExtIRQ !== 1'b0 || pending[2] !== 1'b1) begin
            errors++;
            $display("FAIL lvl_withdraw: ExtIRQ=%b pend2=%b required 0 1", ExtIRQ, pending[2]);
        end
        irq_mask[2] = 1'b0;
        expQ.push_back(ID_W'(2));
        waitExt("lvl_unmask", 4);
        pulseAck();
        checks++;
        if (irq_busy !== 1'b1 || pending[2] !== 1'b1) begin
            errors++;
            $display("FAIL lvl_ack_keep: busy=%b pend2=%b required 1 1", irq_busy, pending[2]);
        end
        pulseEoi();
        expQ.push_back(ID_W'(2));
        tick(1);
        waitExt("lvl_rereq", 0);
        irq_in[2] = 1'b0;
        tick(5);
        checks++;
        if (ExtIRQ !== 1'b0 || pending[2] !== 1'b0) begin
            errors++;
            $display("FAIL lvl_drop: ExtIRQ=%b pend2=%b required 0 0", ExtIRQ, pending[2]);
        end
    endtask

    task automatic test_overflow();
        expQ.push_back(ID_W'(4));
        irq_in[4] = 1'b1; tick(2);
        irq_in[4] = 1'b0; tick(2);
        irq_in[4] = 1'b1; tick(2);
        irq_in[4] = 1'b0; tick(3);
        checks++;
        if (overflow !== 8'h10) begin
            errors++;
            $display("FAIL ovf_set: got %h required 10", overflow);
        end
        waitExt("ovf_req", 2);
        pulseAck();
        pulseEoi();
        tick(3);
        checks++;
        if (ExtIRQ !== 1'b0 || pending[4] !== 1'b0) begin
            errors++;
            $display("FAIL ovf_single: ExtIRQ=%b pend4=%b required 0 0", ExtIRQ, pending[4]);
        end
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        checks++;
        if (overflow !== '0) begin
            errors++;
            $display("FAIL ovf_clr: got %h required 00", overflow);
        end
    endtask

    task automatic test_reset_in_service();
        irq_in[6] = 1'b1;
        irq_in[7] = 1'b1;
        expQ.push_back(ID_W'(6));
        tick(2);
        irq_in = '0;
        waitExt("rst_req", 8);
        pulseAck();
        checks++;
        if (irq_busy !== 1'b1 || pending[7] !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre: busy=%b pend7=%b required 1 1", irq_busy, pending[7]);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({ExtIRQ, irq_busy, irq_id, pending} !== '0) begin
            errors++;
            $display("FAIL rst_async: ExtIRQ=%b busy=%b id=%0d pend=%h required all 0",
                     ExtIRQ, irq_busy, irq_id, pending);
        end
        tick(2);
        reset = 1'b1;
        pulseAck();
        pulseEoi();
        tick(1);
        checks++;
        if (ExtIRQ !== 1'b0 || irq_busy !== 1'b0) begin
            errors++;
            $display("FAIL stray_ack_eoi: ExtIRQ=%b busy=%b required 0 0", ExtIRQ, irq_busy);
        end
    endtask

    task automatic test_short_pulse();
        expQ.push_back(ID_W'(0));
        #7 irq_in[0] = 1'b1;
        @(posedge CLOCK_50);
        #2 irq_in[0] = 1'b0;
        tick(1);
        waitExt("short_req", 8);
        checks++;
        if (overflow[0] !== 1'b0) begin
            errors++;
            $display("FAIL short_ovf: got %b required 0", overflow[0]);
        end
        pulseAck();
        pulseEoi();
        tick(4);
        checks++;
        if (ExtIRQ !== 1'b0 || pending !== '0) begin
            errors++;
            $display("FAIL short_once: ExtIRQ=%b pend=%h required 0 00", ExtIRQ, pending);
        end
    endtask

    initial begin
        test_reset();
        test_edge_latency();
        test_priority();
        test_level_mask();
        test_overflow();
        test_reset_in_service();
        test_short_pulse();
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
